lcd_frame_capture: RTL and testbench
====================================

// Module: lcd_frame_capture
// PURPOSE
//   Downstream of the SM510 core. Demultiplexes the time-multiplexed LCD drive
//   (H commons, segA/segB, Bs) into a double-buffered 4x32 segment frame.
//   The video renderer reads the frame through a random-access bit port.
//   Also reports frame completion, sync loss and a stale or halted display.
// PARAMETERS
//   MAIN_CLK        90000000          system clock frequency in Hz
//   TIMEOUT_CYC     MAIN_CLK/256      idle cycles without a valid H step before stale
//   PERSIST_FRAMES  3                 frames a lit segment persists (LCD_PERSIST_EN only)
// PORTS
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   H          in   4   one-hot common select from core
//   segA       in   16  segment bits 15:0 for the current common
//   segB       in   16  segment bits 31:16 for the current common
//   Bs         in   1   backplane segment bit for the current common
//   rd_addr    in   7   {com[1:0], seg[4:0]} read address
//   rd_data    out  1   segment state at rd_addr, one-cycle latency
//   bs_frame   out  4   front-buffer Bs per common
//   frame_rdy  out  1   one-cycle pulse when the front buffer is swapped
//   frame_cnt  out  8   completed-frame counter, wraps 255->0
//   sync_err   out  1   sticky flag; cleared only by reset
//   stale      out  1   high while the watchdog has expired
// BEHAVIOUR
//   Reset values (async, rst_n=0):
//     - both buffers and bs_frame are 0; rd_data=0, frame_rdy=0.
//     - frame_cnt=0, sync_err=0, stale=0, H_q=0, capture mask=0, watchdog=0.
//   Step detection:
//     - a step is a cycle where H != H_q and H is one-hot.
//     - H=0 or multi-hot: no capture; H_q still updates; watchdog not reloaded.
//   Capture (on a step, com = index of set bit):
//     - back[com] <= {segB,segA}; back_bs[com] <= Bs; mask[com] <= 1.
//     - segA/segB/Bs are sampled in the same cycle the step is detected.
//   Expected order is com 0,1,2,3,0,... A step that is not
//   (last_com+1) mod 4 sets sync_err. The data is still captured.
//   Frame close, on a step to com 0:
//     - mask==4'hF: swap front/back, pulse frame_rdy next cycle,
//       frame_cnt++, then mask <= 4'b0001 (the com-0 row just captured).
//     - mask!=4'hF: no swap, no pulse, sync_err<=1, mask <= 4'b0001.
//     - the very first com-0 step after reset closes nothing.
//   Read port:
//     - rd_data <= front[rd_addr[6:5]][rd_addr[4:0]], registered.
//     - a read in the swap cycle returns the pre-swap front buffer.
//     - a read in the following cycle returns the new frame.
//   Watchdog:
//     - counts cycles since the last valid step; reloads to 0 on each step.
//     - on reaching TIMEOUT_CYC: stale<=1, front buffer and bs_frame cleared
//       (blank display), mask<=0.
//     - the count saturates.
//     - stale falls on the next completed frame swap, not on the first step.
//   Simultaneous watchdog expiry and a step: the step wins; the counter reloads.
//   Only the captured bits depend on segA/segB/Bs. State is driven only by H
//   and the watchdog.
// CONFIGURATION
//   LCD_PERSIST_EN defined:
//     - each of the 128 segments has a 2-bit counter.
//     - at each swap: bit set -> load PERSIST_FRAMES; else decrement if nonzero.
//     - rd_data = (counter != 0), registered, same one-cycle latency.
//     - watchdog blanking also clears the counters.
//   LCD_PERSIST_EN undefined:
//     - no counters; rd_data is the raw front-buffer bit.
// TESTING
//   1. Reset then H=1,2,4,8,1 with segA=16'hA5A5 on com0 and segB=16'h0001 on com3:
//      frame_rdy pulses once, frame_cnt=1, rd_addr=7'h00 -> 1, rd_addr=7'h70 -> 1.
//   2. Sequence H=1,2,8,1: sync_err=1, no frame_rdy, front buffer unchanged.
//   3. H=4'b0011 inserted mid-frame: no capture and no sync_err; the frame still
//      completes on the next H=1.
//   4. Hold H constant for TIMEOUT_CYC cycles: stale=1 and all reads return 0.
//      After a full 1,2,4,8,1 cycle, stale=0 and frame_rdy pulses.
//   5. Read rd_addr=7'h05 in the swap cycle: rd_data is the old value.
//      Read in the next cycle: rd_data is the new value.
//   6. LCD_PERSIST_EN with PERSIST_FRAMES=3: segment lit in one frame then dark
//      reads 1,1,1,0 over the next four frames.
//      Without the macro it reads 1,0.

Source files
------------

// File: rtl/lcd_frame_capture.sv
// Demultiplexes the SM510 time-multiplexed LCD drive into a double-buffered 4x32 segment frame.
// Optional per-segment persistence is enabled by defining LCD_PERSIST_EN.
module lcd_frame_capture #(
   parameter int unsigned MAIN_CLK       = 90000000,
   parameter int unsigned TIMEOUT_CYC    = MAIN_CLK / 256,
   parameter int unsigned PERSIST_FRAMES = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  H,
   input  logic [15:0] segA,
   input  logic [15:0] segB,
   input  logic        Bs,
   input  logic [6:0]  rd_addr,
   output logic        rd_data,
   output logic [3:0]  bs_frame,
   output logic        frame_rdy,
   output logic [7:0]  frame_cnt,
   output logic        sync_err,
   output logic        stale
);

   localparam int unsigned     WD_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

   if (PERSIST_FRAMES > 3) begin : g_bad_persist
      $error("PERSIST_FRAMES must fit the 2-bit persistence counters");
   end

   logic [3:0]        h_q, h_d;
   logic [3:0][31:0]  back_q, back_d, front_q, front_d;
   logic [3:0]        back_bs_q, back_bs_d, front_bs_q, front_bs_d;
   logic [3:0]        mask_q, mask_d;
   logic [1:0]        last_com_q, last_com_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              rd_data_q, rd_data_d;
   logic              frame_rdy_q, frame_rdy_d;
   logic [7:0]        frame_cnt_q, frame_cnt_d;
   logic              sync_err_q, sync_err_d;
   logic              stale_q, stale_d;

   logic              onehot, step, swap, expire;
   logic [1:0]        com;

   assign onehot = (H != 4'd0) && ((H & (H - 4'd1)) == 4'd0);
   assign step   = onehot && (H != h_q);
   assign swap   = step && (com == 2'd0) && (mask_q == 4'hF);
   assign expire = !step && (wd_q == WD_MAX - 1'b1);

   always_comb begin
      com = 2'd0;
      case (H)
         4'b0010: com = 2'd1;
         4'b0100: com = 2'd2;
         4'b1000: com = 2'd3;
         default: com = 2'd0;
      endcase
   end

   always_comb begin
      h_d         = H;
      back_d      = back_q;
      back_bs_d   = back_bs_q;
      front_d     = front_q;
      front_bs_d  = front_bs_q;
      mask_d      = mask_q;
      last_com_d  = last_com_q;
      wd_d        = wd_q;
      frame_rdy_d = 1'b0;
      frame_cnt_d = frame_cnt_q;
      sync_err_d  = sync_err_q;
      stale_d     = stale_q;
      if (step) begin
         back_d[com]    = {segB, segA};
         back_bs_d[com] = Bs;
         last_com_d     = com;
         wd_d           = '0;
         if (com != last_com_q + 2'd1) sync_err_d = 1'b1;
         if (com == 2'd0) begin
            // Front takes the pre-capture back rows; the new com-0 row opens the next frame.
            if (swap) begin
               front_d     = back_q;
               front_bs_d  = back_bs_q;
               frame_rdy_d = 1'b1;
               frame_cnt_d = frame_cnt_q + 8'd1;
               stale_d     = 1'b0;
            end else if (mask_q != 4'd0) begin
               sync_err_d = 1'b1;
            end
            mask_d = 4'b0001;
         end else begin
            mask_d[com] = 1'b1;
         end
      end else if (wd_q != WD_MAX) begin
         wd_d = wd_q + 1'b1;
         if (expire) begin
            // Blanking restarts frame assembly as if fresh out of reset.
            stale_d    = 1'b1;
            front_d    = '0;
            front_bs_d = '0;
            mask_d     = '0;
            last_com_d = 2'd3;
         end
      end
   end

`ifdef LCD_PERSIST_EN
   localparam logic [1:0] PERSIST_LD = 2'(PERSIST_FRAMES);

   logic [127:0]      back_flat;
   logic [127:0][1:0] cnt_q, cnt_d;

   assign back_flat = back_q;

   always_comb begin
      cnt_d = cnt_q;
      if (swap) begin
         for (int unsigned i = 0; i < 128; i++) begin
            if (back_flat[i[6:0]])
               cnt_d[i[6:0]] = PERSIST_LD;
            else if (cnt_q[i[6:0]] != 2'd0)
               cnt_d[i[6:0]] = cnt_q[i[6:0]] - 2'd1;
         end
      end else if (expire) begin
         cnt_d = '0;
      end
   end

   assign rd_data_d = (cnt_q[rd_addr] != 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   logic [127:0] front_flat;

   assign front_flat = front_q;
   assign rd_data_d  = front_flat[rd_addr];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q         <= '0;
         back_q      <= '0;
         back_bs_q   <= '0;
         front_q     <= '0;
         front_bs_q  <= '0;
         mask_q      <= '0;
         last_com_q  <= 2'd3;
         wd_q        <= '0;
         rd_data_q   <= 1'b0;
         frame_rdy_q <= 1'b0;
         frame_cnt_q <= '0;
         sync_err_q  <= 1'b0;
         stale_q     <= 1'b0;
      end else begin
         h_q         <= h_d;
         back_q      <= back_d;
         back_bs_q   <= back_bs_d;
         front_q     <= front_d;
         front_bs_q  <= front_bs_d;
         mask_q      <= mask_d;
         last_com_q  <= last_com_d;
         wd_q        <= wd_d;
         rd_data_q   <= rd_data_d;
         frame_rdy_q <= frame_rdy_d;
         frame_cnt_q <= frame_cnt_d;
         sync_err_q  <= sync_err_d;
         stale_q     <= stale_d;
      end
   end

   assign rd_data   = rd_data_q;
   assign bs_frame  = front_bs_q;
   assign frame_rdy = frame_rdy_q;
   assign frame_cnt = frame_cnt_q;
   assign sync_err  = sync_err_q;
   assign stale     = stale_q;

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Scoreboard bench for lcd_frame_capture: stimulus queues expected reads/frames, a monitor pops them.
module tb_lcd_frame_capture;

   localparam int unsigned TMO = 64;
`ifdef LCD_PERSIST_EN
   localparam bit PERSIST = 1'b1;
`else
   localparam bit PERSIST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  H = '0;
   logic [15:0] segA = '0;
   logic [15:0] segB = '0;
   logic        Bs = 1'b0;
   logic [6:0]  rd_addr = '0;
   logic        rd_data;
   logic [3:0]  bs_frame;
   logic        frame_rdy;
   logic [7:0]  frame_cnt;
   logic        sync_err;
   logic        stale;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [7:0] cnt;
      logic [3:0] bs;
   } frame_t;

   logic   rd_req = 1'b0;
   logic   rd_vld = 1'b0;
   logic   rd_exp_q[$];
   frame_t fq[$];

   lcd_frame_capture #(
      .MAIN_CLK(90000000),
      .TIMEOUT_CYC(TMO),
      .PERSIST_FRAMES(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .H(H),
      .segA(segA),
      .segB(segB),
      .Bs(Bs),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .bs_frame(bs_frame),
      .frame_rdy(frame_rdy),
      .frame_cnt(frame_cnt),
      .sync_err(sync_err),
      .stale(stale)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_vld <= rd_req;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rd_vld) begin
         if (rd_exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rd_unexpected: read result with empty scoreboard at %0t", $time);
         end else begin
            logic e;
            e = rd_exp_q.pop_front();
            check("rd_data", 32'(rd_data), 32'(e));
         end
      end
      if (frame_rdy) begin
         if (fq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame_rdy_unexpected: got 1 expected 0 at %0t", $time);
         end else begin
            frame_t f;
            f = fq.pop_front();
            check("frame_cnt", 32'(frame_cnt), 32'(f.cnt));
            check("bs_frame", 32'(bs_frame), 32'(f.bs));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      rd_req = 1'b0;
   endtask

   task automatic put(input logic [3:0] h, input logic [15:0] a, input logic [15:0] b, input logic bs);
      cyc();
      H    = h;
      segA = a;
      segB = b;
      Bs   = bs;
   endtask

   task automatic rd(input logic [6:0] addr, input logic exp);
      rd_addr = addr;
      rd_req  = 1'b1;
      rd_exp_q.push_back(exp);
   endtask

   task automatic rd_next(input logic [6:0] addr, input logic exp);
      cyc();
      rd(addr, exp);
   endtask

   task automatic expect_frame(input logic [7:0] cnt, input logic [3:0] bs);
      frame_t f;
      f.cnt = cnt;
      f.bs  = bs;
      fq.push_back(f);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_rd_data", 32'(rd_data), 32'd0);
      check("reset_frame_rdy", 32'(frame_rdy), 32'd0);
      check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
      check("reset_sync_err", 32'(sync_err), 32'd0);
      check("reset_stale", 32'(stale), 32'd0);
      check("reset_bs_frame", 32'(bs_frame), 32'd0);
      rst_n = 1'b1;

      // Frame 1: first com-0 step closes nothing
      put(4'b0001, 16'hA5A5, 16'h0000, 1'b1);
      put(4'b0010, 16'h0000, 16'h0000, 1'b0);
      put(4'b0100, 16'h0000, 16'h0000, 1'b1);
      put(4'b1000, 16'h0000, 16'h0001, 1'b0);
      put(4'b0001, 16'h0000, 16'h0000, 1'b0);
      expect_frame(8'd1, 4'b0101);
      rd_next(7'h00, 1'b1);
      rd_next(7'h70, 1'b1);
      rd_next(7'h01, 1'b0);
      rd_next(7'h02, 1'b1);
      rd_next(7'h20, 1'b0);
      cyc();
      check("t1_sync_err", 32'(sync_err), 32'd0);

      // Frame 2 with a multi-hot H inserted mid-frame
      put(4'b0010, 16'h0002, 16'h0000, 1'b1);
      put(4'b0011, 16'hFFFF, 16'hFFFF, 1'b1);
      put(4'b0100, 16'h0000, 16'h0000, 1'b0);
      put(4'b1000, 16'h0000, 16'h8000, 1'b1);
      put(4'b0001, 16'h0020, 16'h0000, 1'b1);
      expect_frame(8'd2, 4'b1010);
      rd_next(7'h21, 1'b1);
      rd_next(7'h7F, 1'b1);
      rd_next(7'h00, PERSIST);
      rd_next(7'h40, 1'b0);
      cyc();
      check("t3_sync_err", 32'(sync_err), 32'd0);
      check("t3_frame_cnt", 32'(frame_cnt), 32'd2);

      // Frame 3: read seg 0x05 in the swap cycle and the cycle after
      put(4'b0010, 16'h0000, 16'h0000, 1'b0);
      put(4'b0100, 16'h0000, 16'h0000, 1'b0);
      put(4'b1000, 16'h0000, 16'h0000, 1'b0);
      put(4'b0001, 16'h0000, 16'h0000, 1'b0);
      rd(7'h05, PERSIST);
      expect_frame(8'd3, 4'b0001);
      rd_next(7'h05, 1'b1);

      // Frames 4..6: seg 0x05 dark, persistence decays
      for (int f = 4; f <= 6; f++) begin
         put(4'b0010, (f == 6) ? 16'h0002 : 16'h0000, 16'h0000, 1'b0);
         put(4'b0100, 16'h0000, 16'h0000, 1'b0);
         put(4'b1000, 16'h0000, 16'h0000, 1'b0);
         put(4'b0001, 16'h0000, 16'h0000, 1'b0);
         expect_frame(8'(f), 4'b0000);
         rd_next(7'h05, (f < 6) ? PERSIST : 1'b0);
      end
      rd_next(7'h21, 1'b1);

      // Out-of-order commons: sync error, no swap
      put(4'b0010, 16'h0000, 16'h0000, 1'b0);
      put(4'b1000, 16'h0000, 16'hFFFF, 1'b1);
      put(4'b0001, 16'h0000, 16'h0000, 1'b0);
      cyc();
      cyc();
      check("t2_sync_err", 32'(sync_err), 32'd1);
      check("t2_frame_cnt", 32'(frame_cnt), 32'd6);
      check("t2_bs_frame", 32'(bs_frame), 32'd0);
      rd(7'h21, 1'b1);
      rd_next(7'h70, 1'b0);

      // Watchdog expiry blanks the display; recovery on the next full frame
      cyc();
      H = 4'b0000;
      repeat (TMO + 8) cyc();
      check("t4_stale_set", 32'(stale), 32'd1);
      check("t4_bs_blank", 32'(bs_frame), 32'd0);
      rd(7'h21, 1'b0);
      rd_next(7'h00, 1'b0);
      rd_next(7'h7F, 1'b0);
      put(4'b0001, 16'h0008, 16'h0000, 1'b1);
      put(4'b0010, 16'h0000, 16'h0000, 1'b0);
      check("t4_stale_after_step", 32'(stale), 32'd1);
      put(4'b0100, 16'h0000, 16'h0000, 1'b0);
      put(4'b1000, 16'h0000, 16'h0000, 1'b0);
      put(4'b0001, 16'h0000, 16'h0000, 1'b0);
      expect_frame(8'd7, 4'b0001);
      cyc();
      check("t4_stale_clear", 32'(stale), 32'd0);
      rd(7'h03, 1'b1);
      rd_next(7'h21, 1'b0);

      repeat (4) cyc();
      check("reads_pending", 32'(rd_exp_q.size()), 32'd0);
      check("frames_pending", 32'(fq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
